// File: rtl/pipeline_hazard_controller_if.sv
// Handshake bundle between the hazard controller and its pipeline.
// The master drives the hazard inputs; the slave returns stall/flush controls.
interface pipeline_hazard_controller_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  isMiss;
  logic                  isMemBusy;
  logic                  isDataHazard;
  logic                  isBranchHazard;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  fetchVirtualStall;
  logic                  redirectActive;
  logic                  stallTimeout;
  logic [CNT_WIDTH-1:0]  stallCycleCount;
  logic [CNT_WIDTH-1:0]  missCount;

  modport master (
    output isMiss, isMemBusy, isDataHazard, isBranchHazard,
    input  stall, flush, fetchVirtualStall, redirectActive,
    input  stallTimeout, stallCycleCount, missCount
  );

  modport slave (
    input  isMiss, isMemBusy, isDataHazard, isBranchHazard,
    output stall, flush, fetchVirtualStall, redirectActive,
    output stallTimeout, stallCycleCount, missCount
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Per-stage stall/flush generator for an N-stage in-order pipeline,
// with multi-cycle redirect, stall watchdog and saturating counters.
module pipeline_hazard_controller #(
  parameter int NUM_STAGES      = 5,
  parameter int DH_STAGE        = 2,
  parameter int MISS_STAGE      = 2,
  parameter int MEM_STAGE       = 3,
  parameter int REDIRECT_CYCLES = 1,
  parameter int STALL_TIMEOUT   = 1024,
  parameter int CNT_WIDTH       = 32
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_controller_if.slave bus
);

  localparam int WW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {RUN, REDIRECT} state_e;

  state_e                state_q, state_d;
  logic [3:0]            redir_q, redir_d;
  logic                  branch_q;
  logic [WW-1:0]         wd_q, wd_d;
  logic                  to_q, to_d;
  logic [CNT_WIDTH-1:0]  scnt_q, scnt_d;
  logic [CNT_WIDTH-1:0]  mcnt_q, mcnt_d;
  logic [NUM_STAGES-1:0] stall_c, flush_c;
  logic                  fvs_c;

  always_comb begin
    stall_c = '0;
    flush_c = '0;
    fvs_c   = 1'b0;
    state_d = state_q;
    redir_d = redir_q;
    priority case (1'b1)
      bus.isMiss: begin
        for (int i = 0; i < NUM_STAGES; i++)
          if (i >= 1 && i <= MISS_STAGE) flush_c[i] = 1'b1;
        redir_d = 4'(REDIRECT_CYCLES - 1);
        state_d = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
      end
      bus.isMemBusy: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i <= MEM_STAGE)     stall_c[i] = 1'b1;
          if (i == MEM_STAGE + 1) flush_c[i] = 1'b1;
        end
        fvs_c = 1'b1;
      end
      (state_q == REDIRECT): begin
        flush_c[1] = 1'b1;
        redir_d    = redir_q - 4'd1;
        if (redir_q == 4'd1) state_d = RUN;
      end
      bus.isDataHazard: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i < DH_STAGE)  stall_c[i] = 1'b1;
          if (i == DH_STAGE) flush_c[i] = 1'b1;
        end
        fvs_c = 1'b1;
      end
      default: begin
        stall_c[0] = bus.isBranchHazard;
        fvs_c      = branch_q;
      end
    endcase
  end

  // Watchdog saturates at the timeout so it never wraps back under it
  always_comb begin
    if (!stall_c[0])
      wd_d = '0;
    else if (wd_q == WW'(STALL_TIMEOUT))
      wd_d = wd_q;
    else
      wd_d = wd_q + WW'(1);
    to_d   = to_q | (wd_d == WW'(STALL_TIMEOUT));
    scnt_d = scnt_q;
    mcnt_d = mcnt_q;
    if ((|stall_c) && !(&scnt_q)) scnt_d = scnt_q + CNT_WIDTH'(1);
    if (bus.isMiss && !(&mcnt_q)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      redir_q  <= '0;
      branch_q <= 1'b0;
      wd_q     <= '0;
      to_q     <= 1'b0;
      scnt_q   <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      redir_q  <= redir_d;
      branch_q <= bus.isBranchHazard;
      wd_q     <= wd_d;
      to_q     <= to_d;
      scnt_q   <= scnt_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign bus.stall             = stall_c;
  assign bus.flush             = flush_c;
  assign bus.fetchVirtualStall = fvs_c;
  assign bus.redirectActive    = (state_q == REDIRECT);
  assign bus.stallTimeout      = to_q;
  assign bus.stallCycleCount   = scnt_q;
  assign bus.missCount         = mcnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomised scoreboard bench for pipeline_hazard_controller.
// A cycle-level reference model predicts outputs; a monitor compares them.
module tb_pipeline_hazard_controller;

  localparam int NS   = 5;
  localparam int DH   = 2;
  localparam int MS   = 2;
  localparam int MEM  = 3;
  localparam int RC   = 4;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_hazard_controller_if #(.NUM_STAGES(NS), .CNT_WIDTH(CW)) b ();

  pipeline_hazard_controller #(
    .NUM_STAGES(NS), .DH_STAGE(DH), .MISS_STAGE(MS), .MEM_STAGE(MEM),
    .REDIRECT_CYCLES(RC), .STALL_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] st;
    logic [NS-1:0] fl;
    logic          fvs;
    logic          ra;
    logic          to;
    logic [CW-1:0] sc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  // Reference model state: owed redirect flushes, previous branch input,
  // run length of fetch stalls, sticky timeout, and event counts.
  int rem, consec, sc, mc;
  bit prevb, tof;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x)
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, x, $time);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall", 32'(b.stall), 32'(e.st));
      chk("flush", 32'(b.flush), 32'(e.fl));
      chk("fetchVirtualStall", 32'(b.fetchVirtualStall), 32'(e.fvs));
      chk("redirectActive", 32'(b.redirectActive), 32'(e.ra));
      chk("stallTimeout", 32'(b.stallTimeout), 32'(e.to));
      chk("stallCycleCount", 32'(b.stallCycleCount), 32'(e.sc));
      chk("missCount", 32'(b.missCount), 32'(e.mc));
    end
  end

  task automatic model_clear();
    rem = 0; consec = 0; sc = 0; mc = 0; prevb = 0; tof = 0;
  endtask

  task automatic drive(input bit m, input bit mb, input bit dh, input bit bh);
    exp_t e;
    logic [NS-1:0] st, fl;
    bit fvs;
    b.isMiss = m; b.isMemBusy = mb; b.isDataHazard = dh; b.isBranchHazard = bh;
    st = '0; fl = '0; fvs = 0;
    e.ra = (rem > 0);
    e.to = tof;
    e.sc = CW'(sc);
    e.mc = CW'(mc);
    if (m) begin
      for (int i = 1; i <= MS; i++) fl[i] = 1'b1;
    end else if (mb) begin
      for (int i = 0; i <= MEM; i++) st[i] = 1'b1;
      if (MEM + 1 < NS) fl[MEM+1] = 1'b1;
      fvs = 1;
    end else if (rem > 0) begin
      fl[1] = 1'b1;
    end else if (dh) begin
      for (int i = 0; i < DH; i++) st[i] = 1'b1;
      fl[DH] = 1'b1;
      fvs = 1;
    end else begin
      st[0] = bh;
      fvs = prevb;
    end
    e.st = st; e.fl = fl; e.fvs = fvs;
    q.push_back(e);
    if (m) rem = RC - 1;
    else if (!mb && rem > 0) rem--;
    prevb = bh;
    consec = st[0] ? consec + 1 : 0;
    if (consec >= TO) tof = 1;
    if ((|st) && sc < MAXC) sc++;
    if (m && mc < MAXC) mc++;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    exp_t e;
    b.isMiss = 0; b.isMemBusy = 0; b.isDataHazard = 0; b.isBranchHazard = 0;
    rst = 1'b1;
    model_clear();
    e.st = '0; e.fl = '0; e.fvs = 0; e.ra = 0; e.to = 0; e.sc = '0; e.mc = '0;
    q.push_back(e);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    b.isMiss = 0; b.isMemBusy = 0; b.isDataHazard = 0; b.isBranchHazard = 0;
    model_clear();
    @(posedge clk); #1;
    apply_reset();
    // single miss pulse
    drive(1, 0, 0, 0);
    repeat (5) drive(0, 0, 0, 0);
    // miss, then memory busy two cycles later freezes the redirect
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    // data hazard suppresses the branch level
    drive(0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0);
    // branch hazard for three cycles
    repeat (3) drive(0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0);
    // watchdog trip from a held data hazard
    apply_reset();
    repeat (10) drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    // miss counter saturation, then reset mid-sequence
    apply_reset();
    repeat (20) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    apply_reset();
    repeat (5) begin
      drive(1, 0, 0, 0);
      drive(0, 0, 0, 0);
    end
    // randomised traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0)
        apply_reset();
      else
        drive($urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 15,
              $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 55);
    end
    drive(0, 0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
